// File: rtl/fb_wr_arbiter.sv
// fb_wr_arbiter: burst-locked two-requester write arbiter feeding the VGA frame-buffer CPU port.
// Round-robin by default; define FB_WR_ARBITER_PRIO_EN for fixed priority to requester 0.
module fb_wr_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 256
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_last,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_last,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              fb_wr,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_data,
    output logic [1:0]        grant
);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_next, tie_pick, rel_pick;
    logic [CW-1:0] beats;
    logic          last_served;
    logic          acc0, acc1, acc, rel;

    assign req0_ready = state == OWN0;
    assign req1_ready = state == OWN1;
    assign grant      = {req1_ready, req0_ready};
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign acc        = acc0 | acc1;
    // beats holds the count before this acceptance, so MAX_BURST-1 marks the final allowed beat
    assign rel        = acc && ((acc0 ? req0_last : req1_last) || beats == CW'(MAX_BURST - 1));

`ifdef FB_WR_ARBITER_PRIO_EN
    assign tie_pick = OWN0;
    assign rel_pick = req0_valid ? OWN0 : req1_valid ? OWN1 : IDLE;
`else
    assign tie_pick = last_served ? OWN0 : OWN1;
    // the other requester is preferred; the releasing one keeps the bus only if alone
    assign rel_pick = acc0 ? (req1_valid ? OWN1 : req0_valid ? OWN0 : IDLE)
                           : (req0_valid ? OWN0 : req1_valid ? OWN1 : IDLE);
`endif

    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = (req0_valid && req1_valid) ? tie_pick :
                         req0_valid ? OWN0 : req1_valid ? OWN1 : IDLE;
        else if (rel)
            state_next = rel_pick;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beats       <= '0;
            last_served <= 1'b1;
            fb_wr       <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
        end else begin
            state <= state_next;
            beats <= rel ? '0 : beats + CW'(acc);
            fb_wr <= acc;
            if (rel)
                last_served <= acc1;
            if (acc) begin
                fb_addr <= acc1 ? req1_addr : req0_addr;
                fb_data <= acc1 ? req1_data : req0_data;
            end
        end
    end
endmodule

// File: tb/tb_fb_wr_arbiter.sv
// tb_fb_wr_arbiter: directed scenarios checked by a cycle-level ownership model plus literal expectations.
// Honors FB_WR_ARBITER_PRIO_EN the same way as the design.
module tb_fb_wr_arbiter;
    localparam int MB = 8;

    logic        pclk = 1'b0, rst_n = 1'b1;
    logic        req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
    logic [31:0] req0_addr = '0, req1_addr = '0, fb_addr;
    logic [7:0]  req0_data = '0, req1_data = '0, fb_data;
    logic        req0_ready, req1_ready, fb_wr;
    logic [1:0]  grant;
    int          n_tests = 0, n_fail = 0;
    logic        f_seen = 1'b0;

    localparam logic [1:0] B_G [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    localparam logic       B_W [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [7:0] B_D [5] = '{8'h00, 8'h10, 8'h11, 8'h20, 8'h21};
    localparam logic [1:0] D_G [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    localparam logic       D_W [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 pclk = ~pclk;

    fb_wr_arbiter #(.ADDR_W(32), .DATA_W(8), .MAX_BURST(MB)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_last(req0_last), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_last(req1_last), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_data(fb_data), .grant(grant)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner (2 = none), beats in current grant, last served, and the write due next cycle
    int          m_own = 2, m_beats = 0, m_ls = 1;
    logic        m_wr = 1'b0;
    logic [31:0] m_addr = '0;
    logic [7:0]  m_data = '0;
    logic        mv [2], ml [2];
    logic [31:0] ma [2];
    logic [7:0]  md [2];

    always @(negedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = 2; m_beats = 0; m_ls = 1; m_wr = 1'b0; m_addr = '0; m_data = '0;
        end
        if (!pclk) begin
            chk("grant", grant, m_own == 0 ? 1 : m_own == 1 ? 2 : 0);
            chk("req0_ready", req0_ready, m_own == 0);
            chk("req1_ready", req1_ready, m_own == 1);
            chk("fb_wr", fb_wr, m_wr);
            chk("fb_addr", fb_addr, m_addr);
            chk("fb_data", fb_data, m_data);
        end
        if (!pclk && rst_n) begin
            mv[0] = req0_valid; ml[0] = req0_last; ma[0] = req0_addr; md[0] = req0_data;
            mv[1] = req1_valid; ml[1] = req1_last; ma[1] = req1_addr; md[1] = req1_data;
            m_wr = 1'b0;
            if (m_own == 2) begin
`ifdef FB_WR_ARBITER_PRIO_EN
                if (mv[0] && mv[1]) m_own = 0;
`else
                if (mv[0] && mv[1]) m_own = (m_ls == 1) ? 0 : 1;
`endif
                else if (mv[0]) m_own = 0;
                else if (mv[1]) m_own = 1;
            end else if (mv[m_own]) begin
                m_wr = 1'b1; m_addr = ma[m_own]; m_data = md[m_own];
                m_beats++;
                if (ml[m_own] || m_beats == MB) begin
                    m_ls = m_own;
                    m_beats = 0;
`ifdef FB_WR_ARBITER_PRIO_EN
                    m_own = mv[0] ? 0 : mv[1] ? 1 : 2;
`else
                    m_own = mv[1 - m_own] ? 1 - m_own : mv[m_own] ? m_own : 2;
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive(input int id, input logic v, input logic [31:0] a, input logic [7:0] d, input logic l);
        if (id == 0) begin
            req0_valid = v; req0_addr = a; req0_data = d; req0_last = l;
        end else begin
            req1_valid = v; req1_addr = a; req1_data = d; req1_last = l;
        end
    endtask

    // Sends n beats, holding each until accepted; optional valid gap of gl cycles after beat gi
    task automatic burst(input int id, input int n, input logic [31:0] a, input logic [7:0] d,
                         input logic [7:0] dinc, input logic last_on, input int gi, input int gl);
        for (int i = 0; i < n; i++) begin
            int   waited;
            logic r;
            waited = 0;
            drive(id, 1'b1, a + i, d + dinc * 8'(i), last_on && i == n - 1);
            do begin
                r = (id == 0) ? req0_ready : req1_ready;
                tick();
                waited++;
            end while (!r && waited < 100);
            if (!r) begin
                n_tests++;
                n_fail++;
                $display("FAIL burst_timeout: requester %0d beat %0d never accepted", id, i);
                drive(id, 1'b0, '0, '0, 1'b0);
                return;
            end
            if (i + 1 == gi) begin
                drive(id, 1'b0, '0, '0, 1'b0);
                repeat (gl) tick();
            end
        end
        drive(id, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_grant", grant, 2'b00);
        chk("rst_fb_wr", fb_wr, 1'b0);
        chk("rst_fb_addr", fb_addr, 32'h0);
        rst_n = 1'b1;
        tick();

        // single 4-beat burst from requester 0
        fork
            burst(0, 4, 32'h100, 8'hFF, 8'h00, 1'b1, 0, 0);
            begin
                tick();
                chk("a_wr_pre", fb_wr, 1'b0);
                chk("a_grant", grant, 2'b01);
                for (int i = 0; i < 4; i++) begin
                    tick();
                    chk("a_wr", fb_wr, 1'b1);
                    chk("a_addr", fb_addr, 32'h100 + i);
                    chk("a_data", fb_data, 8'hFF);
                end
                tick();
                chk("a_wr_post", fb_wr, 1'b0);
            end
        join

        // both valid from reset, 2-beat bursts each
        do_reset();
        fork
            burst(0, 2, 32'h200, 8'h10, 8'h01, 1'b1, 0, 0);
            burst(1, 2, 32'h300, 8'h20, 8'h01, 1'b1, 0, 0);
            for (int k = 0; k < 5; k++) begin
                tick();
                chk("b_grant", grant, B_G[k]);
                chk("b_wr", fb_wr, B_W[k]);
                chk("b_data", fb_data, B_D[k]);
            end
        join

        // forced release after MB beats of an unterminated req1 stream
        do_reset();
        fork
            burst(1, 12, 32'h400, 8'h40, 8'h01, 1'b0, 0, 0);
            begin
                tick();
                tick();
                burst(0, 2, 32'h500, 8'h50, 8'h01, 1'b1, 0, 0);
            end
            begin
                tick();
                chk("c_grant1", grant, 2'b10);
                for (int i = 0; i < MB; i++) begin
                    tick();
                    chk("c_wr", fb_wr, 1'b1);
                    chk("c_addr", fb_addr, 32'h400 + i);
                end
                chk("c_grant_sw", grant, 2'b01);
                tick();
                chk("c_addr_r0", fb_addr, 32'h500);
            end
        join

        // owner stalls 3 cycles mid-burst; lock holds
        do_reset();
        fork
            burst(0, 4, 32'h600, 8'h60, 8'h01, 1'b1, 2, 3);
            burst(1, 2, 32'h700, 8'h70, 8'h01, 1'b1, 0, 0);
            for (int k = 0; k < 8; k++) begin
                tick();
                chk("d_grant", grant, D_G[k]);
                chk("d_wr", fb_wr, D_W[k]);
                chk("d_r1_ready", req1_ready, k == 7);
            end
        join

        // asynchronous reset mid-burst
        do_reset();
        drive(0, 1'b1, 32'h800, 8'h88, 1'b0);
        tick();
        tick();
        tick();
        chk("e_wr_pre", fb_wr, 1'b1);
        chk("e_addr_pre", fb_addr, 32'h800);
        #2 rst_n = 1'b0;
        #1;
        chk("e_wr_rst", fb_wr, 1'b0);
        chk("e_grant_rst", grant, 2'b00);
        chk("e_addr_rst", fb_addr, 32'h0);
        chk("e_data_rst", fb_data, 8'h00);
        chk("e_r0_ready_rst", req0_ready, 1'b0);
        drive(1, 1'b1, 32'h900, 8'h99, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("e_tie_r0", grant, 2'b01);

        // both requesters streaming 2-beat bursts
        do_reset();
        fork
            repeat (3) burst(0, 2, 32'hA00, 8'hA0, 8'h01, 1'b1, 0, 0);
            begin
`ifdef FB_WR_ARBITER_PRIO_EN
                drive(1, 1'b1, 32'hB00, 8'hB0, 1'b1);
                for (int k = 0; k < 12; k++) begin
                    tick();
                    f_seen = f_seen | req1_ready;
                end
                drive(1, 1'b0, '0, '0, 1'b0);
                chk("f_req1_starved", f_seen, 1'b0);
`else
                repeat (2) burst(1, 2, 32'hB00, 8'hB0, 8'h01, 1'b1, 0, 0);
`endif
            end
        join
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
